// File: rtl/pixel_draw_arbiter.sv
// pixel_draw_arbiter: grants one drawing engine at a time and registers its
// pixel stream onto the VGA adapter port (x/y/colour/plot).
// Ports: clk, resetn (async, active low); per-channel req/px_valid/px_last and
// flattened px_x_in/px_y_in/px_c_in; outputs grant/px_ready (one-hot owner),
// x/y/colour/plot (registered pixel), busy (owning), pix_count (burst pixels).
// Optional: define PIXEL_DRAW_ARBITER_COUNT_EN to enable the pix_count counter.
module pixel_draw_arbiter #(
   parameter int NCH = 4,
   parameter int XW  = 9,
   parameter int YW  = 9,
   parameter int CW  = 3,
   parameter int RR  = 1
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [NCH-1:0]    req,
   input  logic [NCH-1:0]    px_valid,
   input  logic [NCH-1:0]    px_last,
   input  logic [NCH*XW-1:0] px_x_in,
   input  logic [NCH*YW-1:0] px_y_in,
   input  logic [NCH*CW-1:0] px_c_in,
   output logic [NCH-1:0]    grant,
   output logic [NCH-1:0]    px_ready,
   output logic [XW-1:0]     x,
   output logic [YW-1:0]     y,
   output logic [CW-1:0]     colour,
   output logic              plot,
   output logic              busy,
   output logic [15:0]       pix_count
);

   localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

   typedef enum logic {IDLE, OWN} state_t;

   state_t         state_q, state_d;
   logic [PW-1:0]  ptr_q, ptr_d;
   logic [NCH-1:0] grant_q, grant_d;
   logic [XW-1:0]  x_q, x_d;
   logic [YW-1:0]  y_q, y_d;
   logic [CW-1:0]  c_q, c_d;
   logic           plot_q, plot_d;

   logic [PW-1:0]  win_idx;
   logic           win_found;
   logic [PW-1:0]  g_idx;
   logic [PW-1:0]  g_nxt;
   logic           acc;

   // First requester at or after the start index, wrapping.
   always_comb begin
      int unsigned start;
      int unsigned j;
      start     = (RR != 0) ? int'(ptr_q) : 0;
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = 0; k < NCH; k++) begin
         j = (start + k) % NCH;
         if (!win_found && req[j]) begin
            win_found = 1'b1;
            win_idx   = PW'(j);
         end
      end
   end

   always_comb begin
      g_idx = '0;
      for (int i = 0; i < NCH; i++) begin
         if (grant_q[i]) g_idx = PW'(i);
      end
   end

   assign g_nxt = (int'(g_idx) == NCH - 1) ? '0 : g_idx + PW'(1);

   // grant_q is zero outside OWN, so acc only fires for the owner.
   assign acc = |(px_valid & grant_q);

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      unique case (state_q)
         IDLE: begin
            if (win_found) begin
               state_d          = OWN;
               grant_d          = '0;
               grant_d[win_idx] = 1'b1;
            end
         end
         OWN: begin
            // Last pixel or dropped request ends the burst; the pixel
            // offered on that cycle is still accepted.
            if ((acc && px_last[g_idx]) || !req[g_idx]) begin
               state_d = IDLE;
               grant_d = '0;
               ptr_d   = g_nxt;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_comb begin
      plot_d = acc;
      x_d    = x_q;
      y_d    = y_q;
      c_d    = c_q;
      if (acc) begin
         x_d = px_x_in[int'(g_idx)*XW +: XW];
         y_d = px_y_in[int'(g_idx)*YW +: YW];
         c_d = px_c_in[int'(g_idx)*CW +: CW];
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
         x_q     <= '0;
         y_q     <= '0;
         c_q     <= '0;
         plot_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         x_q     <= x_d;
         y_q     <= y_d;
         c_q     <= c_d;
         plot_q  <= plot_d;
      end
   end

`ifdef PIXEL_DRAW_ARBITER_COUNT_EN
   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (state_q == IDLE && win_found) begin
         cnt_d = '0;
      end else if (acc && cnt_q != 16'hFFFF) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign pix_count = cnt_q;
`else
   assign pix_count = '0;
`endif

   assign grant    = grant_q;
   assign px_ready = grant_q;
   assign x        = x_q;
   assign y        = y_q;
   assign colour   = c_q;
   assign plot     = plot_q;
   assign busy     = (state_q == OWN);

endmodule

// File: tb/tb_pixel_draw_arbiter.sv
// tb_pixel_draw_arbiter: directed vector table plus corner sequences
// for pixel_draw_arbiter (round-robin instance and fixed-priority instance).
module tb_pixel_draw_arbiter;

   localparam int NCH = 4;
   localparam int XW  = 9;
   localparam int YW  = 9;
   localparam int CW  = 3;
`ifdef PIXEL_DRAW_ARBITER_COUNT_EN
   localparam bit CEN = 1'b1;
`else
   localparam bit CEN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              resetn;
   logic [NCH-1:0]    req, px_valid, px_last;
   logic [NCH*XW-1:0] px_x_in;
   logic [NCH*YW-1:0] px_y_in;
   logic [NCH*CW-1:0] px_c_in;
   logic [NCH-1:0]    grant, px_ready;
   logic [XW-1:0]     x;
   logic [YW-1:0]     y;
   logic [CW-1:0]     colour;
   logic              plot, busy;
   logic [15:0]       pix_count;

   logic [NCH-1:0]    r0_req, r0_valid, r0_last;
   logic [NCH-1:0]    r0_grant, r0_ready;
   logic [XW-1:0]     r0_x;
   logic [YW-1:0]     r0_y;
   logic [CW-1:0]     r0_c;
   logic              r0_plot, r0_busy;
   logic [15:0]       r0_cnt;

   int nchk = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   pixel_draw_arbiter #(
      .NCH(NCH), .XW(XW), .YW(YW), .CW(CW), .RR(1)
   ) dut (
      .clk(clk), .resetn(resetn), .req(req), .px_valid(px_valid),
      .px_last(px_last), .px_x_in(px_x_in), .px_y_in(px_y_in),
      .px_c_in(px_c_in), .grant(grant), .px_ready(px_ready), .x(x),
      .y(y), .colour(colour), .plot(plot), .busy(busy),
      .pix_count(pix_count)
   );

   pixel_draw_arbiter #(
      .NCH(NCH), .XW(XW), .YW(YW), .CW(CW), .RR(0)
   ) dut0 (
      .clk(clk), .resetn(resetn), .req(r0_req), .px_valid(r0_valid),
      .px_last(r0_last), .px_x_in(px_x_in), .px_y_in(px_y_in),
      .px_c_in(px_c_in), .grant(r0_grant), .px_ready(r0_ready), .x(r0_x),
      .y(r0_y), .colour(r0_c), .plot(r0_plot), .busy(r0_busy),
      .pix_count(r0_cnt)
   );

   typedef struct {
      logic [3:0] rq;
      logic [3:0] vl;
      logic [3:0] ls;
      int         ch;
      int         px;
      int         py;
      int         pc;
      logic [3:0] eg;
      logic       ep;
      logic       eb;
      int         ex;
      int         ey;
      int         ec;
      int         en;
   } vec_t;

   vec_t tv[17];

   task automatic chk(input string nm, input int idx, input int act,
                      input int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s[%0d] got=%0d expected=%0d", nm, idx, act, exp);
      end
   endtask

   // Target channel carries the vector data; others carry distinct junk.
   task automatic apply(input logic [3:0] rq, input logic [3:0] vl,
                        input logic [3:0] ls, input int ch, input int xx,
                        input int yy, input int cc);
      req      = rq;
      px_valid = vl;
      px_last  = ls;
      for (int i = 0; i < NCH; i++) begin
         px_x_in[i*XW +: XW] = (i == ch) ? XW'(xx) : XW'(511 - i);
         px_y_in[i*YW +: YW] = (i == ch) ? YW'(yy) : YW'(500 - i);
         px_c_in[i*CW +: CW] = (i == ch) ? CW'(cc) : ~CW'(cc);
      end
   endtask

   initial begin
      tv[0]  = '{4'b0101, 4'b0000, 4'b0000, 0,  0,  0, 0,
                 4'b0001, 1'b0, 1'b1,  0,  0, 0, 0};
      tv[1]  = '{4'b0101, 4'b0001, 4'b0001, 0,  5,  7, 1,
                 4'b0000, 1'b1, 1'b0,  5,  7, 1, 1};
      tv[2]  = '{4'b0101, 4'b0000, 4'b0000, 0,  0,  0, 0,
                 4'b0100, 1'b0, 1'b1,  5,  7, 1, 0};
      tv[3]  = '{4'b0100, 4'b0101, 4'b0000, 2, 10, 20, 5,
                 4'b0100, 1'b1, 1'b1, 10, 20, 5, 1};
      tv[4]  = '{4'b0100, 4'b0100, 4'b0100, 2, 11, 20, 6,
                 4'b0000, 1'b1, 1'b0, 11, 20, 6, 2};
      tv[5]  = '{4'b0000, 4'b0000, 4'b0000, 0,  0,  0, 0,
                 4'b0000, 1'b0, 1'b0, 11, 20, 6, 2};
      tv[6]  = '{4'b0010, 4'b0000, 4'b0000, 1,  0,  0, 0,
                 4'b0010, 1'b0, 1'b1, 11, 20, 6, 0};
      tv[7]  = '{4'b0010, 4'b0001, 4'b0001, 1, 40, 40, 2,
                 4'b0010, 1'b0, 1'b1, 11, 20, 6, 0};
      tv[8]  = '{4'b0010, 4'b0010, 4'b0000, 1,  1,  2, 3,
                 4'b0010, 1'b1, 1'b1,  1,  2, 3, 1};
      tv[9]  = '{4'b1011, 4'b0010, 4'b0000, 1,  2,  2, 3,
                 4'b0010, 1'b1, 1'b1,  2,  2, 3, 2};
      tv[10] = '{4'b1011, 4'b0010, 4'b0000, 1,  3,  2, 3,
                 4'b0010, 1'b1, 1'b1,  3,  2, 3, 3};
      tv[11] = '{4'b0000, 4'b0000, 4'b0000, 1,  0,  0, 0,
                 4'b0000, 1'b0, 1'b0,  3,  2, 3, 3};
      tv[12] = '{4'b1111, 4'b0000, 4'b0000, 0,  0,  0, 0,
                 4'b0100, 1'b0, 1'b1,  3,  2, 3, 0};
      tv[13] = '{4'b0000, 4'b0000, 4'b0000, 0,  0,  0, 0,
                 4'b0000, 1'b0, 1'b0,  3,  2, 3, 0};
      tv[14] = '{4'b1111, 4'b0000, 4'b0000, 0,  0,  0, 0,
                 4'b1000, 1'b0, 1'b1,  3,  2, 3, 0};
      tv[15] = '{4'b0111, 4'b1000, 4'b1000, 3,  7,  8, 2,
                 4'b0000, 1'b1, 1'b0,  7,  8, 2, 1};
      tv[16] = '{4'b0000, 4'b0000, 4'b0000, 0,  0,  0, 0,
                 4'b0000, 1'b0, 1'b0,  7,  8, 2, 1};

      resetn   = 1'b0;
      r0_req   = '0;
      r0_valid = '0;
      r0_last  = '0;
      apply(4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0);
      #12;
      chk("rst_grant", 0, int'(grant), 0);
      chk("rst_ready", 0, int'(px_ready), 0);
      chk("rst_plot", 0, int'(plot), 0);
      chk("rst_busy", 0, int'(busy), 0);
      chk("rst_xyc", 0, int'({x, y, colour}), 0);
      chk("rst_cnt", 0, int'(pix_count), 0);
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 17; i++) begin
         apply(tv[i].rq, tv[i].vl, tv[i].ls, tv[i].ch,
               tv[i].px, tv[i].py, tv[i].pc);
         @(posedge clk);
         #1;
         chk("grant", i, int'(grant), int'(tv[i].eg));
         chk("px_ready", i, int'(px_ready), int'(tv[i].eg));
         chk("plot", i, int'(plot), int'(tv[i].ep));
         chk("busy", i, int'(busy), int'(tv[i].eb));
         chk("x", i, int'(x), tv[i].ex);
         chk("y", i, int'(y), tv[i].ey);
         chk("colour", i, int'(colour), tv[i].ec);
         chk("pix_count", i, int'(pix_count), CEN ? tv[i].en : 0);
      end

      // Reset pulse between edges in the middle of a burst.
      apply(4'b0001, 4'b0000, 4'b0000, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      chk("mid_grant", 0, int'(grant), 1);
      apply(4'b0001, 4'b0001, 4'b0000, 0, 9, 9, 4);
      @(posedge clk);
      #1;
      chk("mid_plot", 0, int'(plot), 1);
      #2;
      resetn = 1'b0;
      #1;
      chk("arst_grant", 0, int'(grant), 0);
      chk("arst_plot", 0, int'(plot), 0);
      chk("arst_busy", 0, int'(busy), 0);
      chk("arst_xyc", 0, int'({x, y, colour}), 0);
      chk("arst_cnt", 0, int'(pix_count), 0);
      apply(4'b1000, 4'b0000, 4'b0000, 0, 0, 0, 0);
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk);
      #1;
      chk("post_grant", 0, int'(grant), 8);
      chk("post_busy", 0, int'(busy), 1);
      apply(4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0);
      @(posedge clk);
      #1;

      // Fixed priority: channel 1 wins every burst while 1 and 3 request.
      r0_req = 4'b1010;
      for (int b = 0; b < 3; b++) begin
         r0_valid = '0;
         r0_last  = '0;
         @(posedge clk);
         #1;
         chk("fp_grant", b, int'(r0_grant), 2);
         r0_valid = 4'b0010;
         r0_last  = 4'b0010;
         @(posedge clk);
         #1;
         chk("fp_idle", b, int'(r0_grant), 0);
         chk("fp_plot", b, int'(r0_plot), 1);
      end
      r0_req   = '0;
      r0_valid = '0;
      r0_last  = '0;
      @(posedge clk);
      #1;

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
